// File: rtl/store_pkg.sv
// Shared encodings for the store merge unit: store sizes and FSM states.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR
    } state_e;

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops the narrowed store data into the read-back word.
module store_lane_merge
    import store_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  size_e       size,
    input  logic [1:0]  byte_off,
    output logic [31:0] merged
);

    logic [1:0] lane;
    logic       half_hi;

    always_comb begin
        // lane counts bytes upward from bit 0 regardless of endianness
        lane    = BIG_ENDIAN ? ~byte_off : byte_off;
        half_hi = BIG_ENDIAN ? ~byte_off[1] : byte_off[1];
        merged  = old_word;
        case (size)
            SZ_BYTE: merged[{lane, 3'b000} +: 8] = new_data[7:0];
            SZ_HALF: begin
                if (half_hi) merged[31:16] = new_data[15:0];
                else         merged[15:0]  = new_data[15:0];
            end
            SZ_WORD: merged = new_data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_merge_unit.sv
// Store path to a data memory without byte enables; sub-word stores run read-modify-write.
// Optional build macro STORE_MISALIGN_TRAP_EN rejects misaligned half/word stores.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | ready for a request; err pulse lands here
//   ST_RD_REQ  | one-cycle read strobe for the target word
//   ST_RD_WAIT | waiting for read data, merge on arrival
//   ST_WR      | write strobe with final word, done pulse
module store_merge_unit
    import store_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_data,
    output logic              done,
    output logic              err
);

    state_e            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    size_e             size_q;
    logic [31:0]       word_q;
    logic              err_q;
    logic [31:0]       merged;
    logic              accept;
    logic              bad_req;
    size_e             req_sz;

    store_lane_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_merge (
        .old_word (mem_rd_data),
        .new_data (data_q),
        .size     (size_q),
        .byte_off (addr_q[1:0]),
        .merged   (merged)
    );

    always_comb begin
        req_sz = size_e'(req_size);
        accept = req_valid && (state == ST_IDLE);
`ifdef STORE_MISALIGN_TRAP_EN
        bad_req = (req_sz == SZ_RSVD)
               || ((req_sz == SZ_HALF) && req_addr[0])
               || ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        bad_req = (req_sz == SZ_RSVD);
`endif
    end

    always_comb begin
        state_nx    = state;
        req_ready   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (accept && !bad_req)
                    state_nx = (req_sz == SZ_WORD) ? ST_WR : ST_RD_REQ;
            end
            ST_RD_REQ: begin
                mem_rd_en = 1'b1;
                state_nx  = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_rd_valid) state_nx = ST_WR;
            end
            ST_WR: begin
                mem_wr_en   = 1'b1;
                mem_wr_data = word_q;
                done        = 1'b1;
                state_nx    = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            data_q <= '0;
            size_q <= SZ_BYTE;
            word_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= accept && bad_req;
            if (accept) begin
                addr_q <= req_addr;
                data_q <= req_data;
                size_q <= req_sz;
                if (req_sz == SZ_WORD) word_q <= req_data;
            end
            if ((state == ST_RD_WAIT) && mem_rd_valid) word_q <= merged;
        end
    end

    assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign err      = err_q;

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Store-side counterpart to the load/immediate extension path in the 4-stage MIPS pipeline.
- Takes a 32-bit register value and a store size (SB/SH/SW). Narrows the value to the addressed byte or halfword lane(s) and produces a full-word memory write.
- Data memory has no byte enables, so sub-word stores use a read-modify-write sequence. The pipeline is stalled while that sequence runs.
- Sits between the EX/MEM boundary and the data memory port.

Parameters:
- BIG_ENDIAN, 1: 1 = byte offset 0 maps to bits [31:24] (MIPS big-endian); 0 = byte offset 0 maps to bits [7:0].
- ADDR_W, 32: address width.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request; low = stall the pipeline.
- req_addr  in  ADDR_W  byte address.
- req_data  in  32  register value to store; only the low 8 or 16 bits are used for SB/SH.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2], 2'b00}).
- mem_rd_en  out  1  single-cycle read strobe.
- mem_rd_data  in  32  read data.
- mem_rd_valid  in  1  read data valid; arrives 1 or more cycles after mem_rd_en.
- mem_wr_en  out  1  single-cycle write strobe.
- mem_wr_data  out  32  merged write word.
- done  out  1  one-cycle pulse when the store completes.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset values: all outputs 0 except req_ready = 1; FSM in IDLE; request registers cleared.
- States: IDLE, RD_REQ, RD_WAIT, WR.
- Handshake:
  - A request is accepted when req_valid && req_ready.
  - req_ready = 1 only in IDLE.
  - addr, data and size are latched on acceptance; inputs are ignored afterwards.
- SW path: IDLE -> WR.
  - Accepted in cycle N.
  - Cycle N+1: mem_wr_en = 1, mem_wr_data = req_data, done = 1; return to IDLE.
  - Latency 1, no read issued.
- SB/SH path: IDLE -> RD_REQ -> RD_WAIT -> WR -> IDLE.
  - RD_REQ: mem_rd_en = 1 for one cycle.
  - RD_WAIT: hold until mem_rd_valid, then capture mem_rd_data.
  - WR (the cycle after rd_valid): mem_wr_en = 1, mem_wr_data = merged word, done = 1.
  - Minimum latency with 1-cycle read: accept N, rd_en N+1, rd_valid N+2, write/done N+3.
- Merge rule:
  - Byte: lane = addr[1:0]; req_data[7:0] replaces that lane; other 3 bytes come from the read word.
  - Half: lane = addr[1]; req_data[15:0] replaces that halfword. With BIG_ENDIAN = 1, addr[1] = 0 selects [31:16].
  - Upper bits of req_data beyond the store width are discarded and never affect the result.
- mem_addr is held stable from RD_REQ through WR.
- Reserved size (11): no memory access; err pulses in the cycle after acceptance; return to IDLE.
- mem_rd_valid outside RD_WAIT is ignored.
- Reset in any state: return to IDLE next edge; no mem_wr_en is issued for the aborted store; any in-flight read data is ignored.
- done and err never assert in the same cycle.

Optional Feature:
- Macro STORE_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with addr[0] = 1, or a word with addr[1:0] != 0, is rejected.
  - err pulses the cycle after acceptance; no memory access is made.
- Undefined:
  - Misaligned low address bits are ignored: half uses addr[1] only, word uses the word address.
  - The store proceeds normally and err is never raised for alignment.

Decomposition:
- Package store_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - FSM state encodings.
- Sub-module store_lane_merge: purely combinational.
  - Inputs: old word, new data, size, addr[1:0], BIG_ENDIAN.
  - Output: merged word.
- The FSM and registers live in the top-level module.

Test Plan:
- SW: addr 0x100, data 0xDEADBEEF -> one cycle later mem_wr_en = 1, mem_addr 0x100, wr_data 0xDEADBEEF, done = 1, mem_rd_en never asserted.
- SB: addr 0x203, data 0xFFFFFF5A, memory returns 0x11223344 (BIG_ENDIAN = 1) -> wr_data 0x1122335A, mem_addr 0x200, req_ready low for 3 cycles.
- SH: addr 0x202, data 0x0000ABCD, memory returns 0x11223344 with 3-cycle read latency -> wr_data 0x1122ABCD; write occurs exactly 1 cycle after rd_valid.
- Reserved size 11 -> err pulse 1 cycle after acceptance; no rd_en or wr_en.
- Reset asserted in RD_WAIT, then rd_valid arrives -> no mem_wr_en, no done, req_ready = 1 after reset.
- Misaligned SH at addr 0x201:
  - with STORE_MISALIGN_TRAP_EN -> err, no memory access;
  - without it -> treated as addr 0x200, write to [31:16].
